pipe_stage_reg: RTL



---
 rtl/pipe_pkg.sv | 13 +
 rtl/pipe_slot.sv | 29 ++
 rtl/pipe_stage_reg.sv | 122 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the generic inter-stage pipeline register.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKIDF = 2'd2
  } pipe_state_t;

  // Bubble payload: the MIPS nop encodes as all zeros.
  localparam int unsigned PIPE_NOP = 0;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: WIDTH-bit payload plus valid flag, with clear priority over load.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic             valid,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid <= 1'b0;
      q     <= WIDTH'(PIPE_NOP);
    end else if (clear) begin
      valid <= 1'b0;
      q     <= WIDTH'(PIPE_NOP);
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Reusable pipeline latch with valid/ready handshake, optional skid entry,
// flush-to-bubble and a saturating stall-cycle counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SKID  = 0,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  pipe_state_t      state, next_state;
  logic             accept, do_release;
  logic             main_load, main_clear, skid_load, skid_clear;
  logic [WIDTH-1:0] main_d, main_q, skid_q;
  logic             main_valid, skid_valid;

  assign out_valid  = main_valid;
  assign out_data   = main_valid ? main_q : WIDTH'(PIPE_NOP);
  assign occupancy  = {1'b0, main_valid} + {1'b0, skid_valid};
  assign accept     = in_valid & in_ready;
  assign do_release = out_valid & out_ready & ~stall;

  generate
    if (SKID != 0) begin : g_skid
      // Registered ready: the skid entry absorbs the beat in flight when out_ready drops.
      assign in_ready = nRST & ~stall & (state != SKIDF);

      pipe_slot #(.WIDTH(WIDTH)) u_skid (
        .CLK  (CLK),
        .nRST (nRST),
        .load (skid_load),
        .clear(skid_clear),
        .d    (in_data),
        .valid(skid_valid),
        .q    (skid_q)
      );
    end else begin : g_noskid
      logic unused_skid;
      assign in_ready    = nRST & ~stall & ((state == EMPTY) | out_ready);
      assign skid_valid  = 1'b0;
      assign skid_q      = WIDTH'(PIPE_NOP);
      assign unused_skid = skid_load ^ skid_clear;
    end
  endgenerate

  pipe_slot #(.WIDTH(WIDTH)) u_main (
    .CLK  (CLK),
    .nRST (nRST),
    .load (main_load),
    .clear(main_clear),
    .d    (main_d),
    .valid(main_valid),
    .q    (main_q)
  );

  always_comb begin
    next_state = state;
    main_load  = 1'b0;
    main_clear = 1'b0;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    main_d     = in_data;
    if (flush) begin
      next_state = EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      unique case (state)
        EMPTY: if (accept) begin
          main_load  = 1'b1;
          next_state = FULL;
        end
        FULL: begin
          if (accept && do_release) begin
            main_load = 1'b1;
          end else if (accept) begin
            skid_load  = 1'b1;
            next_state = SKIDF;
          end else if (do_release) begin
            main_clear = 1'b1;
            next_state = EMPTY;
          end
        end
        SKIDF: if (do_release) begin
          main_load  = 1'b1;
          main_d     = skid_q;
          skid_clear = 1'b1;
          next_state = FULL;
        end
        default: next_state = EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= EMPTY;
    else       state <= next_state;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
    end else if (!flush && ((out_valid && !out_ready) || stall) &&
                 (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
